// File: rtl/membus_width_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : membus_width_bridge
//  Purpose  : Adapts a narrow core-side bus (byte address, ILEN-bit data) to a
//             wide memory-side bus (word address, MEM_DATA_WIDTH-bit data).
//             Picks the ILEN lane out of each wide word on reads. Narrow writes
//             become read-modify-write, because the memory bus has no byte
//             mask. Only one transaction is in flight at a time.
//  Ports    : clk_i          clock, rising edge
//             rst_ni         asynchronous reset, active-low
//             core_valid_i   core request valid
//             core_ready_o   bridge can accept a request (IDLE only)
//             core_addr_i    core byte address
//             core_wen_i     1 = write
//             core_wdata_i   core write data
//             core_rvalid_o  one-cycle response pulse per accepted request
//             core_rdata_o   response data (old lane value for writes)
//             mem_valid_o    memory request valid
//             mem_ready_i    memory accepts request
//             mem_addr_o     memory word address
//             mem_wen_o      memory write
//             mem_wdata_o    full-word write data
//             mem_rvalid_i   memory response pulse (reads and writes)
//             mem_rdata_i    memory read data
//  Revision : 1.0  initial release
// ============================================================================
module membus_width_bridge #(
   parameter int ILEN           = 32,
   parameter int XLEN           = 32,
   parameter int MEM_DATA_WIDTH = 64,
   parameter int MEM_ADDR_WIDTH = 20
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      core_valid_i,
   output logic                      core_ready_o,
   input  logic [XLEN-1:0]           core_addr_i,
   input  logic                      core_wen_i,
   input  logic [ILEN-1:0]           core_wdata_i,
   output logic                      core_rvalid_o,
   output logic [ILEN-1:0]           core_rdata_o,
   output logic                      mem_valid_o,
   input  logic                      mem_ready_i,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic                      mem_wen_o,
   output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                      mem_rvalid_i,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int OFS    = $clog2(MEM_DATA_WIDTH / 8);
   localparam int LOFS   = $clog2(ILEN / 8);
   localparam int R      = MEM_DATA_WIDTH / ILEN;
   localparam int LANE_W = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_WAIT = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic                      wen_q, wen_d;
   logic [ILEN-1:0]           wdata_q, wdata_d;
   logic [ILEN-1:0]           old_q, old_d;
   logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [ILEN-1:0]           rdata_q, rdata_d;

   logic [LANE_W-1:0]         w_lane_in;
   logic [ILEN-1:0]           w_lane_old;
   logic [MEM_DATA_WIDTH-1:0] w_merged;
   logic                      w_accept;

   // Lane field only exists when a memory word holds more than one core word.
   generate
      if (R > 1) begin : g_lane
         assign w_lane_in = core_addr_i[OFS-1:LOFS];
      end else begin : g_no_lane
         assign w_lane_in = '0;
      end
   endgenerate

   // Sub-word offset bits and address bits above the memory range are
   // deliberately discarded (no misalignment error, addresses wrap).
   generate
      if (LOFS > 0) begin : g_lo_unused
         logic w_unused_lo;
         assign w_unused_lo = ^core_addr_i[LOFS-1:0];
      end
      if (XLEN > OFS + MEM_ADDR_WIDTH) begin : g_hi_unused
         logic w_unused_hi;
         assign w_unused_hi = ^core_addr_i[XLEN-1:OFS+MEM_ADDR_WIDTH];
      end
   endgenerate

   // Extract the addressed lane and build the write-merged word in one pass.
   always_comb begin
      w_lane_old = '0;
      w_merged   = mem_rdata_i;
      for (int k = 0; k < R; k++) begin
         if (lane_q == LANE_W'(k)) begin
            w_lane_old                 = mem_rdata_i[k*ILEN +: ILEN];
            w_merged[k*ILEN +: ILEN]   = wdata_q;
         end
      end
   end

   // Ready is gated by reset so the core sees 0 for the whole reset window.
   assign core_ready_o  = rst_ni && (state_q == S_IDLE);
   assign w_accept      = core_valid_i && core_ready_o;
   assign mem_valid_o   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
   assign mem_wen_o     = (state_q == S_WR_REQ);
   assign mem_addr_o    = mem_addr_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign core_rvalid_o = (state_q == S_RESP);
   assign core_rdata_o  = rdata_q;

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      lane_d      = lane_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      old_d       = old_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               mem_addr_d = core_addr_i[OFS+MEM_ADDR_WIDTH-1:OFS];
               lane_d     = w_lane_in;
               wen_d      = core_wen_i;
               wdata_d    = core_wdata_i;
               if (core_wen_i && (R == 1)) begin
                  // Full-width write: no read phase needed.
                  mem_wdata_d             = '0;
                  mem_wdata_d[ILEN-1:0]   = core_wdata_i;
                  state_d                 = S_WR_REQ;
               end else begin
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (mem_ready_i) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_rvalid_i) begin
               if (wen_q) begin
                  old_d       = w_lane_old;
                  mem_wdata_d = w_merged;
                  state_d     = S_WR_REQ;
               end else begin
                  rdata_d = w_lane_old;
                  state_d = S_RESP;
               end
            end
         end
         S_WR_REQ: begin
            if (mem_ready_i) state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (mem_rvalid_i) begin
               // Writes return the pre-write lane; full-width writes return 0.
               rdata_d = (R > 1) ? old_q : '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         lane_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         old_q       <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         lane_q      <= lane_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         old_q       <= old_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_membus_width_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_membus_width_bridge
//  Purpose  : Self-checking bench for membus_width_bridge (default parameters)
//             with a one-cycle-latency memory model and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_membus_width_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_valid;
   logic        core_ready;
   logic [31:0] core_addr;
   logic        core_wen;
   logic [31:0] core_wdata;
   logic        core_rvalid;
   logic [31:0] core_rdata;
   logic        mem_valid;
   logic        mem_ready;
   logic [19:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;

   membus_width_bridge #(
      .ILEN(32), .XLEN(32), .MEM_DATA_WIDTH(64), .MEM_ADDR_WIDTH(20)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .core_valid_i(core_valid), .core_ready_o(core_ready),
      .core_addr_i(core_addr), .core_wen_i(core_wen), .core_wdata_i(core_wdata),
      .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
      .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
      .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic        ready_en = 1'b1;
   logic        spur     = 1'b0;
   logic        pl_en    = 1'b0;
   logic [7:0]  pl_addr  = '0;
   logic [63:0] pl_data  = '0;
   logic [63:0] mem [0:255];
   logic        mrvalid_q = 1'b0;
   logic [63:0] mrdata_q  = '0;
   logic [63:0] last_wdata = '0;
   logic [19:0] last_waddr = '0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [11:0] unused_hi;

   assign unused_hi  = mem_addr[19:8];
   assign mem_ready  = ready_en;
   assign mem_rvalid = mrvalid_q | spur;
   assign mem_rdata  = mrdata_q;

   always @(posedge clk) begin
      mrvalid_q <= 1'b0;
      if (pl_en) mem[pl_addr] <= pl_data;
      if (rst_n && mem_valid && mem_ready) begin
         mrvalid_q <= 1'b1;
         if (mem_wen) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            n_wr       <= n_wr + 1;
            last_wdata <= mem_wdata;
            last_waddr <= mem_addr;
         end else begin
            mrdata_q <= mem[mem_addr[7:0]];
            n_rd     <= n_rd + 1;
         end
      end
   end

   int cyc = 0;
   int rv_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_rvalid) rv_cnt <= rv_cnt + 1;
   end

   // ---------------- checking ----------------
   int          errors = 0;
   int          checks = 0;
   int          rv_seen = 0;
   int          resp_cyc = 0;
   int          acc_cyc = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle; any response seen is matched against the scoreboard.
   task automatic step();
      logic [31:0] exp_v;
      @(negedge clk);
      if (core_rvalid) begin
         resp_cyc = cyc;
         rv_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", core_rvalid, 0);
         end else begin
            exp_v = exp_q.pop_front();
            chk("rdata", core_rdata, exp_v);
         end
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [63:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      step();
      pl_en   = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic push, input logic [31:0] exp, input logic hold);
      logic acc;
      acc        = 1'b0;
      core_addr  = a;
      core_wen   = w;
      core_wdata = d;
      core_valid = 1'b1;
      for (int i = 0; i < 40 && !acc; i++) begin
         if (core_ready) begin
            acc     = 1'b1;
            acc_cyc = cyc;
            if (push) exp_q.push_back(exp);
         end
         step();
      end
      if (!hold) core_valid = 1'b0;
      chk("accept", acc, 1);
   endtask

   task automatic wait_resp();
      int start;
      start = rv_seen;
      for (int i = 0; i < 60 && rv_seen == start; i++) step();
      chk("resp_seen", rv_seen - start, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          rv0;
      int          rd0;
      int          wr0;
      logic        found;
      int          acc_t[3];
      logic [31:0] a6[3];
      logic [31:0] e6[3];

      rst_n = 1'b0; core_valid = 1'b0; core_addr = '0; core_wen = 1'b0; core_wdata = '0;
      repeat (3) step();
      // Reset state
      chk("rst_core_ready", core_ready, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_core_rvalid", core_rvalid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_core_rdata", core_rdata, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", core_ready, 1);
      step();

      // 1: read lane 1 of word 0x20
      preload(8'h20, 64'hDEADBEEF_01234567);
      rv0 = rv_cnt;
      issue(32'h0000_0104, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
      chk("t1_mem_valid", mem_valid, 1);
      chk("t1_mem_addr", mem_addr, 20'h20);
      chk("t1_mem_wen", mem_wen, 0);
      wait_resp();
      chk("t1_latency", resp_cyc - acc_cyc, 3);
      step();
      chk("t1_rvalid_pulses", rv_cnt - rv0, 1);
      chk("t1_rdata_hold", core_rdata, 32'hDEADBEEF);

      // 2: read-modify-write of lane 0
      preload(8'h20, 64'h11112222_33334444);
      rd0 = n_rd; wr0 = n_wr; rv0 = rv_cnt;
      issue(32'h0000_0100, 1'b1, 32'hAAAABBBB, 1'b1, 32'h33334444, 1'b0);
      wait_resp();
      chk("t2_latency", resp_cyc - acc_cyc, 5);
      step();
      chk("t2_rvalid_pulses", rv_cnt - rv0, 1);
      chk("t2_mem_reads", n_rd - rd0, 1);
      chk("t2_mem_writes", n_wr - wr0, 1);
      chk("t2_merged", last_wdata, 64'h11112222_AAAABBBB);
      chk("t2_waddr", last_waddr, 20'h20);

      // 3: backpressure in RD_REQ
      preload(8'h21, 64'h55556666_77778888);
      ready_en = 1'b0;
      issue(32'h0000_010C, 1'b0, 32'h0, 1'b1, 32'h55556666, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("t3_mem_valid", mem_valid, 1);
         chk("t3_mem_addr", mem_addr, 20'h21);
         chk("t3_core_ready", core_ready, 0);
         step();
      end
      ready_en = 1'b1;
      wait_resp();
      step();

      // 4: spurious memory response while idle
      rv0 = rv_cnt;
      spur = 1'b1;
      step();
      spur = 1'b0;
      chk("t4_ready", core_ready, 1);
      chk("t4_rvalid", core_rvalid, 0);
      step();
      step();
      chk("t4_no_pulse", rv_cnt - rv0, 0);

      // 5: reset asserted during WR_REQ
      rv0 = rv_cnt; wr0 = n_wr;
      issue(32'h0000_0100, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_valid && mem_wen) begin
            found    = 1'b1;
            ready_en = 1'b0;
         end else begin
            step();
         end
      end
      chk("t5_reached_wr_req", found, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_mem_valid", mem_valid, 0);
      chk("t5_async_mem_wen", mem_wen, 0);
      chk("t5_ready_in_reset", core_ready, 0);
      step();
      step();
      rst_n = 1'b0;
      rst_n = 1'b1;
      ready_en = 1'b1;
      #1;
      chk("t5_ready_after", core_ready, 1);
      chk("t5_mem_addr_cleared", mem_addr, 0);
      repeat (8) step();
      chk("t5_no_pulse", rv_cnt - rv0, 0);
      chk("t5_no_write", n_wr - wr0, 0);

      // 6: back-to-back reads with core_valid held high
      preload(8'h00, 64'hA0A0A0A0_B0B0B0B0);
      preload(8'h01, 64'hC0C0C0C0_D0D0D0D0);
      a6[0] = 32'h0; a6[1] = 32'h4; a6[2] = 32'h8;
      e6[0] = 32'hB0B0B0B0; e6[1] = 32'hA0A0A0A0; e6[2] = 32'hD0D0D0D0;
      for (int i = 0; i < 3; i++) begin
         issue(a6[i], 1'b0, 32'h0, 1'b1, e6[i], 1'b1);
         acc_t[i] = acc_cyc;
      end
      core_valid = 1'b0;
      wait_resp();
      chk("t6_gap01", acc_t[1] - acc_t[0], 4);
      chk("t6_gap12", acc_t[2] - acc_t[1], 4);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
